obi_copy_master: RTL and testbench

// - OBI initiator that copies LEN 32-bit words from SRC to DST over one OBI data port; drives the SoC SRAM data port via the data-side mux.
// - Software or a controller loads src/dst/len and pulses start; block issues read-then-write pairs, one transaction outstanding.
// - Reports completion and error via done pulse and error code; bus errors come from the responder's illegal-access flag.

---
 rtl/obi_copy_master.sv | 104 ++++++++++
 tb/tb_obi_copy_master.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/obi_copy_master.sv
// obi_copy_master: OBI initiator copying len 32-bit words from src to dst, one transaction outstanding.
// Ports: clk_i/rst_ni (async active-low); start_i, src_addr_i, dst_addr_i, len_i load a job in IDLE;
//        busy_o, done_o, err_code_o (00 ok, 01 bus error, 10 timeout) report status;
//        obi_req_o/gnt_i/addr_o/we_o/be_o/wdata_o/rvalid_i/rdata_i form the OBI data port;
//        bus_err_i flags an illegal access at the request handshake.
// Optional: define OBI_COPY_TIMEOUT_EN to abort after TIMEOUT_CYCLES without gnt/rvalid.
module obi_copy_master #(
   parameter int LEN_W          = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [1:0]       err_code_o,
   output logic             obi_req_o,
   input  logic             obi_gnt_i,
   output logic [31:0]      obi_addr_o,
   output logic             obi_we_o,
   output logic [3:0]       obi_be_o,
   output logic [31:0]      obi_wdata_o,
   input  logic             obi_rvalid_i,
   input  logic [31:0]      obi_rdata_i,
   input  logic             bus_err_i
);
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH} state_t;
   state_t state_q, state_d;
   logic [31:0] src_q, dst_q, wdata_q;
   logic [LEN_W-1:0] rem_q;
   logic [1:0] err_q;
   logic abort_q, hs, tmo;
   assign obi_req_o   = state_q == RD_REQ || state_q == WR_REQ;
   assign obi_we_o    = state_q == WR_REQ;
   assign obi_addr_o  = obi_we_o ? dst_q : src_q;
   assign obi_wdata_o = wdata_q;
   assign obi_be_o    = 4'hF;
   assign busy_o      = state_q != IDLE;
   assign done_o      = state_q == FINISH;
   assign err_code_o  = err_q;
   assign hs          = obi_req_o && obi_gnt_i;
`ifdef OBI_COPY_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt_q;
   logic waiting;
   assign waiting = (obi_req_o && !obi_gnt_i) ||
                    ((state_q == RD_WAIT || state_q == WR_WAIT) && !obi_rvalid_i);
   assign tmo = waiting && cnt_q == CNT_LAST;
   // Cleared on every state change so each wait phase gets its own budget.
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt_q <= '0;
      else cnt_q <= (state_d != state_q || !waiting) ? '0 : cnt_q + 1'b1;
`else
   assign tmo = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = (len_i == '0) ? FINISH : RD_REQ;
         RD_REQ:  if (obi_gnt_i) state_d = RD_WAIT;
         RD_WAIT: if (obi_rvalid_i) state_d = abort_q ? FINISH : WR_REQ;
         WR_REQ:  if (obi_gnt_i) state_d = WR_WAIT;
         WR_WAIT: if (obi_rvalid_i) state_d = (abort_q || rem_q == LEN_W'(1)) ? FINISH : RD_REQ;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (tmo) state_d = FINISH;
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         wdata_q <= '0;
         rem_q   <= '0;
         err_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && start_i) begin
            src_q   <= {src_addr_i[31:2], 2'b00};
            dst_q   <= {dst_addr_i[31:2], 2'b00};
            rem_q   <= len_i;
            err_q   <= 2'b00;
            abort_q <= 1'b0;
         end
         // An errored access still gets its response; abort_q stops further requests.
         if (hs && bus_err_i) begin
            abort_q <= 1'b1;
            err_q   <= 2'b01;
         end
         if (state_q == RD_WAIT && obi_rvalid_i) wdata_q <= obi_rdata_i;
         if (state_q == WR_WAIT && obi_rvalid_i) begin
            src_q <= src_q + 32'd4;
            dst_q <= dst_q + 32'd4;
            rem_q <= rem_q - 1'b1;
         end
         if (tmo) err_q <= 2'b10;
      end
endmodule

// File: tb/tb_obi_copy_master.sv
// tb_obi_copy_master: vector table of copy jobs against an SRAM responder, write scoreboard, hand-written corner cases.
module tb_obi_copy_master;
   logic        clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
   logic [31:0] src_addr_i = '0, dst_addr_i = '0;
   logic [15:0] len_i = '0;
   logic        busy_o, done_o, obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, bus_err_i;
   logic [1:0]  err_code_o;
   logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i;
   logic [3:0]  obi_be_o;

   obi_copy_master dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .src_addr_i(src_addr_i),
      .dst_addr_i(dst_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
      .err_code_o(err_code_o), .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i),
      .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
      .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
      .bus_err_i(bus_err_i)
   );

   always #5 clk_i = ~clk_i;

   logic [31:0] mem [logic [31:0]];
   logic [63:0] exp_q[$], obs_q[$];
   int          req_cyc = 0, hs_cnt = 0, stall_until = 0;
   logic        drop_rv = 1'b0, err_en = 1'b0;
   logic [31:0] err_addr = '0;
   int          nchk = 0, nfail = 0;

   // SRAM responder: grant after the programmed stall, response one cycle after handshake.
   assign obi_gnt_i = obi_req_o && req_cyc >= stall_until;
   assign bus_err_i = obi_req_o && obi_we_o && err_en && obi_addr_o == err_addr;
   initial obi_rvalid_i = 1'b0;
   initial obi_rdata_i = '0;
   always @(posedge clk_i) begin
      obi_rvalid_i <= obi_req_o && obi_gnt_i && !drop_rv;
      if (obi_req_o) req_cyc <= req_cyc + 1;
      if (obi_req_o && obi_gnt_i) begin
         hs_cnt <= hs_cnt + 1;
         if (!obi_we_o) obi_rdata_i <= mem.exists(obi_addr_o) ? mem[obi_addr_o] : 32'hDEAD_BEEF;
         else if (!bus_err_i) obs_q.push_back({obi_addr_o, obi_wdata_o});
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] src, dst, base, eaddr;
      int          len, stall, nwr, cyc, hs;
      logic        een, restart;
      logic [1:0]  err;
   } vec_t;
   vec_t vt[6];

   task automatic run(input vec_t v, input int idx);
      logic [31:0] s, d;
      int cyc, h0;
      logic seen;
      s = {v.src[31:2], 2'b00};
      d = {v.dst[31:2], 2'b00};
      for (int i = 0; i < v.len; i++) begin
         mem[s + 32'(4 * i)] = v.base + 32'(i);
         if (i < v.nwr) exp_q.push_back({d + 32'(4 * i), v.base + 32'(i)});
      end
      err_addr = v.eaddr;
      err_en = v.een;
      @(negedge clk_i);
      stall_until = req_cyc + v.stall;
      h0 = hs_cnt;
      src_addr_i = v.src;
      dst_addr_i = v.dst;
      len_i = 16'(v.len);
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      cyc = 1;
      chk($sformatf("v%0d busy_after_start", idx), busy_o, 1);
      while (!done_o && cyc < 400) begin
         if (v.stall > 0 && obi_req_o && !obi_gnt_i) begin
            chk($sformatf("v%0d stall_addr", idx), obi_addr_o, s);
            chk($sformatf("v%0d stall_we", idx), obi_we_o, 0);
         end
         start_i = v.restart && cyc == 3;
         len_i = start_i ? 16'd7 : len_i;
         @(negedge clk_i);
         cyc++;
      end
      start_i = 1'b0;
      seen = done_o;
      chk($sformatf("v%0d done_seen", idx), seen, 1);
      chk($sformatf("v%0d done_cycle", idx), cyc, v.cyc);
      chk($sformatf("v%0d err_code", idx), err_code_o, v.err);
      chk($sformatf("v%0d busy_at_done", idx), busy_o, 1);
      @(negedge clk_i);
      chk($sformatf("v%0d busy_after", idx), busy_o, 0);
      chk($sformatf("v%0d done_pulse", idx), done_o, 0);
      repeat (3) @(negedge clk_i);
      chk($sformatf("v%0d handshakes", idx), hs_cnt - h0, v.hs);
      chk($sformatf("v%0d err_held", idx), err_code_o, v.err);
      chk($sformatf("v%0d write_count", idx), obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0)
         chk($sformatf("v%0d write", idx), obs_q.pop_front(), exp_q.pop_front());
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int cyc;
      logic seen;
      //        src            dst            base           eaddr          len stall nwr cyc hs een  restart err
      vt[0] = '{32'h8000_0000, 32'h8000_0100, 32'h0000_0001, 32'h0,         3, 0, 3, 13, 6, 1'b0, 1'b0, 2'b00};
      vt[1] = '{32'h8000_0000, 32'h8000_0100, 32'h0000_0000, 32'h0,         0, 0, 0,  1, 0, 1'b0, 1'b0, 2'b00};
      vt[2] = '{32'h1000_0000, 32'h1000_0040, 32'hA5A5_0000, 32'h0,         2, 5, 2, 14, 4, 1'b0, 1'b0, 2'b00};
      vt[3] = '{32'h2000_0000, 32'h7FFF_FFF8, 32'h1234_5670, 32'h7FFF_FFFC, 3, 0, 1,  9, 4, 1'b1, 1'b0, 2'b01};
      vt[4] = '{32'hFFFF_FFFC, 32'h3000_0000, 32'hCAFE_0010, 32'h0,         2, 0, 2,  9, 4, 1'b0, 1'b1, 2'b00};
      vt[5] = '{32'h4000_0003, 32'h4000_0102, 32'h0BAD_F00D, 32'h0,         1, 0, 1,  5, 2, 1'b0, 1'b0, 2'b00};
      repeat (3) @(negedge clk_i);
      chk("rst_req", obi_req_o, 0);
      chk("rst_we", obi_we_o, 0);
      chk("rst_addr", obi_addr_o, 0);
      chk("rst_wdata", obi_wdata_o, 0);
      chk("rst_be", obi_be_o, 4'hF);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_code_o, 0);
      rst_ni = 1'b1;
      for (int i = 0; i < 6; i++) run(vt[i], i);
      // Response never returns: hangs by default, times out with the option built in.
      drop_rv = 1'b1;
      stall_until = req_cyc;
      mem[32'h5000_0000] = 32'h5555_AAAA;
      src_addr_i = 32'h5000_0000;
      dst_addr_i = 32'h5000_0100;
      len_i = 16'd1;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      cyc = 1;
      seen = 1'b0;
      while (cyc < 200) begin
         if (done_o && !seen) begin
            seen = 1'b1;
`ifdef OBI_COPY_TIMEOUT_EN
            chk("tmo_cycle", cyc, 66);
            chk("tmo_err", err_code_o, 2'b10);
`endif
         end
         @(negedge clk_i);
         cyc++;
      end
`ifdef OBI_COPY_TIMEOUT_EN
      chk("tmo_done_seen", seen, 1);
      chk("tmo_idle", busy_o, 0);
`else
      chk("hang_no_done", seen, 0);
      chk("hang_busy", busy_o, 1);
      chk("hang_err", err_code_o, 0);
`endif
      rst_ni = 1'b0;
      #1;
      chk("hang_rst_busy", busy_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      drop_rv = 1'b0;
      obs_q.delete();
      // Reset while a request is held waiting for grant.
      stall_until = req_cyc + 1000;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("mid_req_high", obi_req_o, 1);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_req", obi_req_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_addr", obi_addr_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      stall_until = req_cyc;
      repeat (3) @(negedge clk_i);
      chk("post_rst_idle", obi_req_o, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
